// File: rtl/generador_vga_param.sv
// generador_vga_param: parametrised VGA timing and windowed frame-buffer scan with outputs delayed to match RAM read latency
module generador_vga_param #(
  parameter int          H_ACTIVE   = 640,
  parameter int          H_FP       = 16,
  parameter int          H_SYNC     = 96,
  parameter int          H_BP       = 48,
  parameter int          V_ACTIVE   = 480,
  parameter int          V_FP       = 10,
  parameter int          V_SYNC     = 2,
  parameter int          V_BP       = 33,
  parameter int          IMG_W      = 256,
  parameter int          IMG_H      = 256,
  parameter int          IMG_X0     = 192,
  parameter int          IMG_Y0     = 112,
  parameter int          SCALE_LOG2 = 0,
  parameter int          RD_LAT     = 2,
  parameter int          ADDR_W     = 18,
  parameter logic [23:0] BG_COLOR   = 24'h000000
) (
  input  logic              clock_25,
  input  logic              reset,
  input  logic              enable,
  input  logic [23:0]       data_pixel,
  output logic [ADDR_W-1:0] address,
  output logic              re,
  output logic [7:0]        red,
  output logic [7:0]        green,
  output logic [7:0]        blue,
  output logic              hsync,
  output logic              vsync,
  output logic              n_blank,
  output logic              frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);
  localparam int WIN_W = IMG_W << SCALE_LOG2;
  localparam int WIN_H = IMG_H << SCALE_LOG2;
  localparam int CW = $clog2(IMG_W + 1);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] X_BEG  = HW'(IMG_X0);
  localparam logic [HW-1:0] X_END  = HW'(IMG_X0 + WIN_W);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] Y_BEG  = VW'(IMG_Y0);
  localparam logic [VW-1:0] Y_END  = VW'(IMG_Y0 + WIN_H);
  localparam logic [1:0]    SUB_LAST = 2'((1 << SCALE_LOG2) - 1);
  if (IMG_X0 + WIN_W > H_ACTIVE || IMG_Y0 + WIN_H > V_ACTIVE) begin : g_chk_window
    $error("image window does not fit inside the active area");
  end
  if (longint'(IMG_W) * longint'(IMG_H) > (longint'(1) << ADDR_W)) begin : g_chk_addr
    $error("image does not fit in the RAM address space");
  end
  if (SCALE_LOG2 < 0 || SCALE_LOG2 > 2) begin : g_chk_scale
    $error("SCALE_LOG2 must be 0..2");
  end
  if (RD_LAT < 1) begin : g_chk_lat
    $error("RD_LAT must be at least 1");
  end
  typedef struct packed {
    logic fs;
    logic hs;
    logic vs;
    logic act;
    logic bg;
    logic px;
  } vid_t;
  localparam vid_t VID_RST = '{fs: 1'b0, hs: 1'b1, vs: 1'b1, act: 1'b0, bg: 1'b0, px: 1'b0};
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic h_wrap, v_wrap, hx, vy, win, act, scan;
  logic [1:0] hsub, vsub;
  logic [CW-1:0] col;
  logic [ADDR_W-1:0] row_base, addr_c;
  vid_t raw, o;
  vid_t [RD_LAT:0] pipe;
  logic [23:0] rgb_nx;
  always_comb begin
    h_wrap = h == H_LAST;
    v_wrap = v == V_LAST;
    hx     = h >= X_BEG && h < X_END;
    vy     = v >= Y_BEG && v < Y_END;
    win    = hx && vy;
    act    = h < H_ACT && v < V_ACT;
    scan   = win && enable;
    addr_c = row_base + ADDR_W'(col);
    raw    = '{fs: h == '0 && v == '0, hs: !(h >= HS_BEG && h < HS_END), vs: !(v >= VS_BEG && v < VS_END),
               act: act, bg: act && enable, px: scan};
    o      = pipe[RD_LAT];
    rgb_nx = o.px ? data_pixel : o.bg ? BG_COLOR : 24'h0;
  end
  always_ff @(posedge clock_25 or negedge reset)
    if (!reset) begin
      h <= '0;
      v <= '0;
    end else begin
      h <= h_wrap ? '0 : h + 1'b1;
      if (h_wrap) v <= v_wrap ? '0 : v + 1'b1;
    end
  // Column and row base always describe the current counter position; both are
  // zero by the time the scan reaches the window's top-left pixel.
  always_ff @(posedge clock_25 or negedge reset)
    if (!reset) begin
      hsub     <= '0;
      vsub     <= '0;
      col      <= '0;
      row_base <= '0;
    end else begin
      if (!hx) begin
        hsub <= '0;
        col  <= '0;
      end else if (hsub == SUB_LAST) begin
        hsub <= '0;
        col  <= col + 1'b1;
      end else hsub <= hsub + 1'b1;
      if (h_wrap) begin
        if (!vy) begin
          vsub     <= '0;
          row_base <= '0;
        end else if (vsub == SUB_LAST) begin
          vsub     <= '0;
          row_base <= row_base + ADDR_W'(IMG_W);
        end else vsub <= vsub + 1'b1;
      end
    end
  always_ff @(posedge clock_25 or negedge reset)
    if (!reset) begin
      re      <= 1'b0;
      address <= '0;
    end else begin
      re <= scan;
      if (scan) address <= addr_c;
    end
  always_ff @(posedge clock_25 or negedge reset)
    if (!reset) pipe <= {(RD_LAT + 1){VID_RST}};
    else pipe <= {pipe[RD_LAT-1:0], raw};
  always_ff @(posedge clock_25 or negedge reset)
    if (!reset) {hsync, vsync, n_blank, frame_start, red, green, blue} <= {4'b1100, 24'h0};
    else {hsync, vsync, n_blank, frame_start, red, green, blue} <= {o.hs, o.vs, o.act, o.fs, rgb_nx};
endmodule

// File: tb/tb_generador_vga_param.sv
// tb_generador_vga_param: directed checks of a scaled-down timing set (50x30 frame); u_a unscaled RD_LAT=2, u_b 2x scaled RD_LAT=3
module tb_generador_vga_param;
  localparam int HT = 50, VT = 30;
  localparam logic [23:0] BG = 24'h202020;
  logic clk = 1'b0, reset = 1'b0, enable = 1'b1;
  logic [23:0] data_a, data_b, rgb_a, rgb_b;
  logic [7:0] address_a, address_b, red_a, green_a, blue_a, red_b, green_b, blue_b;
  logic re_a, re_b, hsync_a, hsync_b, vsync_a, vsync_b, n_blank_a, n_blank_b, fs_a, fs_b;
  logic [7:0] qa [2];
  logic [7:0] qb [3];
  bit en_log [0:4095];
  int checks = 0, failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) begin
    qa[0] <= address_a;
    qa[1] <= qa[0];
    qb[0] <= address_b;
    qb[1] <= qb[0];
    qb[2] <= qb[1];
  end
  assign data_a = {16'h0, qa[1]};
  assign data_b = {16'h0, qb[2]};
  assign rgb_a = {red_a, green_a, blue_a};
  assign rgb_b = {red_b, green_b, blue_b};

  generador_vga_param #(.H_ACTIVE(32), .H_FP(4), .H_SYNC(8), .H_BP(6), .V_ACTIVE(20), .V_FP(2), .V_SYNC(3), .V_BP(5),
    .IMG_W(8), .IMG_H(6), .IMG_X0(10), .IMG_Y0(5), .SCALE_LOG2(0), .RD_LAT(2), .ADDR_W(8), .BG_COLOR(BG)) u_a (
    .clock_25(clk), .reset(reset), .enable(enable), .data_pixel(data_a), .address(address_a), .re(re_a),
    .red(red_a), .green(green_a), .blue(blue_a), .hsync(hsync_a), .vsync(vsync_a), .n_blank(n_blank_a),
    .frame_start(fs_a));

  generador_vga_param #(.H_ACTIVE(32), .H_FP(4), .H_SYNC(8), .H_BP(6), .V_ACTIVE(20), .V_FP(2), .V_SYNC(3), .V_BP(5),
    .IMG_W(4), .IMG_H(3), .IMG_X0(10), .IMG_Y0(5), .SCALE_LOG2(1), .RD_LAT(3), .ADDR_W(8), .BG_COLOR(BG)) u_b (
    .clock_25(clk), .reset(reset), .enable(enable), .data_pixel(data_b), .address(address_b), .re(re_b),
    .red(red_b), .green(green_b), .blue(blue_b), .hsync(hsync_b), .vsync(vsync_b), .n_blank(n_blank_b),
    .frame_start(fs_b));

  function automatic int hof(int c); return c % HT; endfunction
  function automatic int vof(int c); return (c / HT) % VT; endfunction
  function automatic bit in_win(int c);
    int h = hof(c);
    int v = vof(c);
    return h >= 10 && h < 18 && v >= 5 && v < 11;
  endfunction
  function automatic bit in_act(int c); return hof(c) < 32 && vof(c) < 20; endfunction
  function automatic int addr_a(int c); return (vof(c) - 5) * 8 + hof(c) - 10; endfunction
  function automatic int addr_b(int c); return ((vof(c) - 5) / 2) * 4 + (hof(c) - 10) / 2; endfunction
  function automatic bit exp_re(int n); return n >= 1 && en_log[n-1] && in_win(n - 1); endfunction
  function automatic logic [3:0] exp_sync(int n, int l);
    int c;
    if (n < l) return 4'b1100;
    c = n - l;
    return {!(hof(c) >= 36 && hof(c) < 44), !(vof(c) >= 22 && vof(c) < 25), in_act(c), hof(c) == 0 && vof(c) == 0};
  endfunction
  function automatic logic [23:0] exp_rgb(int n, int l, bit scaled);
    int c;
    if (n < l) return 24'h0;
    c = n - l;
    if (!en_log[c] || !in_act(c)) return 24'h0;
    if (!in_win(c)) return BG;
    return scaled ? 24'(addr_b(c)) : 24'(addr_a(c));
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    enable = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({hsync_a, vsync_a, n_blank_a, fs_a, re_a} !== 5'b11000) begin
      failures++;
      $display("FAIL reset_ctrl_a got=%b exp=11000", {hsync_a, vsync_a, n_blank_a, fs_a, re_a});
    end
    checks++;
    if (rgb_a !== 24'h0 || address_a !== 8'h0) begin
      failures++;
      $display("FAIL reset_data_a rgb=%h addr=%h exp=0,0", rgb_a, address_a);
    end
    checks++;
    if ({hsync_b, vsync_b, n_blank_b, fs_b, re_b} !== 5'b11000) begin
      failures++;
      $display("FAIL reset_ctrl_b got=%b exp=11000", {hsync_b, vsync_b, n_blank_b, fs_b, re_b});
    end
    checks++;
    if (rgb_b !== 24'h0 || address_b !== 8'h0) begin
      failures++;
      $display("FAIL reset_data_b rgb=%h addr=%h exp=0,0", rgb_b, address_b);
    end
  endtask

  task automatic test_sync;
    int fall0 = -1, fall1 = -1, hlow = 0, vlow = 0, fs0 = -1, fs1 = -1, fs_cnt = 0;
    logic hs_prev = 1'b1;
    do_reset;
    for (int n = 0; n < 3100; n++) begin
      en_log[n] = 1'b1;
      checks++;
      if ({hsync_a, vsync_a, n_blank_a, fs_a} !== exp_sync(n, 4)) begin
        failures++;
        $display("FAIL sync_a n=%0d got=%b exp=%b", n, {hsync_a, vsync_a, n_blank_a, fs_a}, exp_sync(n, 4));
      end
      checks++;
      if ({hsync_b, vsync_b, n_blank_b, fs_b} !== exp_sync(n, 5)) begin
        failures++;
        $display("FAIL sync_b n=%0d got=%b exp=%b", n, {hsync_b, vsync_b, n_blank_b, fs_b}, exp_sync(n, 5));
      end
      if (hs_prev && !hsync_a) begin
        if (fall0 < 0) fall0 = n;
        else if (fall1 < 0) fall1 = n;
      end
      hs_prev = hsync_a;
      if (!hsync_a && n < 90) hlow++;
      if (!vsync_a && n >= 4 && n < 1504) vlow++;
      if (fs_a) begin
        fs_cnt++;
        if (fs0 < 0) fs0 = n;
        else if (fs1 < 0) fs1 = n;
      end
      step;
    end
    checks++;
    if (fall0 != 40 || fall1 != 90) begin
      failures++;
      $display("FAIL hsync_fall got=%0d,%0d exp=40,90", fall0, fall1);
    end
    checks++;
    if (hlow != 8) begin
      failures++;
      $display("FAIL hsync_width got=%0d exp=8", hlow);
    end
    checks++;
    if (vlow != 150) begin
      failures++;
      $display("FAIL vsync_width got=%0d exp=150", vlow);
    end
    checks++;
    if (fs0 != 4 || fs1 != 1504 || fs_cnt != 3) begin
      failures++;
      $display("FAIL frame_start got=%0d,%0d cnt=%0d exp=4,1504 cnt=3", fs0, fs1, fs_cnt);
    end
  endtask

  task automatic test_address;
    int last = 0, re_cnt = 0, hand;
    do_reset;
    for (int n = 0; n < 1600; n++) begin
      en_log[n] = 1'b1;
      if (exp_re(n)) last = addr_a(n - 1);
      checks++;
      if (re_a !== exp_re(n) || address_a !== 8'(last)) begin
        failures++;
        $display("FAIL addr_a n=%0d re=%b/%b addr=%0d/%0d", n, re_a, exp_re(n), address_a, last);
      end
      if (re_a && n <= 1500) re_cnt++;
      if (n == 261 || n == 268 || n == 311 || n == 518) begin
        hand = n == 261 ? 0 : n == 268 ? 7 : n == 311 ? 8 : 47;
        checks++;
        if (re_a !== 1'b1 || address_a !== 8'(hand)) begin
          failures++;
          $display("FAIL addr_corner n=%0d re=%b addr=%0d exp=1,%0d", n, re_a, address_a, hand);
        end
      end
      step;
    end
    checks++;
    if (re_cnt != 48) begin
      failures++;
      $display("FAIL re_count_a got=%0d exp=48", re_cnt);
    end
  endtask

  task automatic test_rgb;
    do_reset;
    for (int n = 0; n < 1600; n++) begin
      en_log[n] = 1'b1;
      checks++;
      if (rgb_a !== exp_rgb(n, 4, 1'b0)) begin
        failures++;
        $display("FAIL rgb_a n=%0d got=%h exp=%h", n, rgb_a, exp_rgb(n, 4, 1'b0));
      end
      if (n == 263 || n == 265 || n == 294 || n == 521) begin
        checks++;
        if (rgb_a !== (n == 263 ? BG : n == 265 ? 24'h000001 : n == 294 ? 24'h0 : 24'h00002f)) begin
          failures++;
          $display("FAIL rgb_corner n=%0d got=%h", n, rgb_a);
        end
      end
      step;
    end
  endtask

  task automatic test_scale;
    int last = 0, re_cnt = 0, hand;
    do_reset;
    for (int n = 0; n < 1600; n++) begin
      en_log[n] = 1'b1;
      if (exp_re(n)) last = addr_b(n - 1);
      checks++;
      if (re_b !== exp_re(n) || address_b !== 8'(last)) begin
        failures++;
        $display("FAIL addr_b n=%0d re=%b/%b addr=%0d/%0d", n, re_b, exp_re(n), address_b, last);
      end
      checks++;
      if (rgb_b !== exp_rgb(n, 5, 1'b1)) begin
        failures++;
        $display("FAIL rgb_b n=%0d got=%h exp=%h", n, rgb_b, exp_rgb(n, 5, 1'b1));
      end
      if (re_b && n <= 1500) re_cnt++;
      if (n == 313 || n == 314 || n == 315 || n == 363) begin
        hand = n == 315 ? 2 : n == 363 ? 5 : 1;
        checks++;
        if (re_b !== 1'b1 || address_b !== 8'(hand)) begin
          failures++;
          $display("FAIL scale_corner n=%0d re=%b addr=%0d exp=1,%0d", n, re_b, address_b, hand);
        end
      end
      step;
    end
    checks++;
    if (re_cnt != 48) begin
      failures++;
      $display("FAIL re_count_b got=%0d exp=48", re_cnt);
    end
  endtask

  task automatic test_enable;
    int zc = 0;
    do_reset;
    for (int n = 0; n < 700; n++) begin
      enable = !(n >= 312 && n < 317);
      en_log[n] = enable;
      checks++;
      if (re_a !== exp_re(n)) begin
        failures++;
        $display("FAIL en_re n=%0d got=%b exp=%b", n, re_a, exp_re(n));
      end
      checks++;
      if (rgb_a !== exp_rgb(n, 4, 1'b0)) begin
        failures++;
        $display("FAIL en_rgb n=%0d got=%h exp=%h", n, rgb_a, exp_rgb(n, 4, 1'b0));
      end
      checks++;
      if ({hsync_a, vsync_a, n_blank_a, fs_a} !== exp_sync(n, 4)) begin
        failures++;
        $display("FAIL en_sync n=%0d got=%b exp=%b", n, {hsync_a, vsync_a, n_blank_a, fs_a}, exp_sync(n, 4));
      end
      if (n >= 316 && n < 321 && rgb_a === 24'h0) zc++;
      if (n == 312 || n == 313 || n == 318) begin
        checks++;
        if (re_a !== (n != 313)) begin
          failures++;
          $display("FAIL en_re_edge n=%0d got=%b", n, re_a);
        end
      end
      if (n == 315 || n == 321) begin
        checks++;
        if (rgb_a !== (n == 315 ? 24'd9 : 24'd15)) begin
          failures++;
          $display("FAIL en_rgb_edge n=%0d got=%h", n, rgb_a);
        end
      end
      step;
    end
    enable = 1'b1;
    checks++;
    if (zc != 5) begin
      failures++;
      $display("FAIL en_gap got=%0d exp=5", zc);
    end
  endtask

  task automatic test_reset_mid;
    int fall0 = -1;
    logic hs_prev = 1'b1;
    do_reset;
    for (int n = 0; n < 414; n++) begin
      en_log[n] = 1'b1;
      step;
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({hsync_a, vsync_a, n_blank_a, fs_a, re_a} !== 5'b11000 || rgb_a !== 24'h0 || address_a !== 8'h0) begin
      failures++;
      $display("FAIL mid_reset got=%b rgb=%h addr=%h", {hsync_a, vsync_a, n_blank_a, fs_a, re_a}, rgb_a, address_a);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    for (int n = 0; n < 150; n++) begin
      en_log[n] = 1'b1;
      checks++;
      if (rgb_a !== exp_rgb(n, 4, 1'b0) || {hsync_a, vsync_a, n_blank_a, fs_a} !== exp_sync(n, 4)) begin
        failures++;
        $display("FAIL mid_after n=%0d rgb=%h sync=%b exp=%h,%b", n, rgb_a, {hsync_a, vsync_a, n_blank_a, fs_a},
                 exp_rgb(n, 4, 1'b0), exp_sync(n, 4));
      end
      if (n == 4) begin
        checks++;
        if (rgb_a !== BG) begin
          failures++;
          $display("FAIL mid_first_pixel got=%h exp=%h", rgb_a, BG);
        end
      end
      if (hs_prev && !hsync_a && fall0 < 0) fall0 = n;
      hs_prev = hsync_a;
      step;
    end
    checks++;
    if (fall0 != 40) begin
      failures++;
      $display("FAIL mid_hsync_fall got=%0d exp=40", fall0);
    end
  endtask

  initial begin
    test_reset;
    test_sync;
    test_address;
    test_rgb;
    test_scale;
    test_enable;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
